// File: rtl/p_uart_tx_if.sv
// Peripheral-bus bundle between the CPU (master) and the UART transmitter (slave).
interface p_uart_tx_if;
  logic       i_p_wr_strobe;
  logic       i_p_rd_strobe;
  logic [7:0] i_p_addr;
  logic [7:0] i_p_din;
  logic [7:0] o_p_dout;
  logic       o_p_rd_done;

  modport master (
    output i_p_wr_strobe, i_p_rd_strobe, i_p_addr, i_p_din,
    input  o_p_dout, o_p_rd_done
  );

  modport slave (
    input  i_p_wr_strobe, i_p_rd_strobe, i_p_addr, i_p_din,
    output o_p_dout, o_p_rd_done
  );
endinterface

// File: rtl/p_uart_tx.sv
// UART transmitter with a 4-deep TX FIFO and a two-register peripheral-bus map
// (TXDATA at base, STATUS at base+1). Frames are 8N1, LSB first.
module p_uart_tx #(
  parameter logic [7:0] P_BASE_ADDR    = 8'h10,
  parameter int         P_CLKS_PER_BIT = 868
) (
  input  logic         i_clk,
  input  logic         i_reset,
  p_uart_tx_if.slave   bus,
  output logic         o_tx,
  output logic         o_busy
);

  localparam logic [15:0] LAST_BAUD = 16'(P_CLKS_PER_BIT - 1);
  localparam logic [7:0]  DATA_ADDR = P_BASE_ADDR;
  localparam logic [7:0]  STAT_ADDR = P_BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [7:0]  fifo_q [4];
  logic [7:0]  fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        rd_done_q, rd_done_d;
  logic [7:0]  dout_q, dout_d;

  logic       baud_last;
  logic       pop;
  logic       push;
  logic       wr_data_hit;
  logic       wr_stat_hit;
  logic       rd_hit;
  logic [7:0] status;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = 1'b0;
    tx_d       = 1'b1;
    baud_last  = (baud_q == LAST_BAUD);

    wr_data_hit = bus.i_p_wr_strobe && (bus.i_p_addr == DATA_ADDR);
    wr_stat_hit = bus.i_p_wr_strobe && (bus.i_p_addr == STAT_ADDR);
    rd_hit      = bus.i_p_rd_strobe &&
                  ((bus.i_p_addr == DATA_ADDR) || (bus.i_p_addr == STAT_ADDR));
    status      = {4'b0, overflow_q, (state_q != S_IDLE), (count_q == 3'd0), (count_q == 3'd4)};

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = 16'd0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d   = S_DATA;
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d    = 16'd0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = 16'd0;
          // Chain straight into the next frame when more data is waiting.
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    // Fullness is judged after this cycle's pop, so a write on a popping cycle still fits.
    if (wr_data_hit) begin
      if ((count_q == 3'd4) && !pop) begin
        overflow_d = 1'b1;
      end else begin
        push             = 1'b1;
        fifo_d[wr_ptr_q] = bus.i_p_din;
        wr_ptr_d         = wr_ptr_q + 2'd1;
      end
    end
    if (wr_stat_hit && bus.i_p_din[3]) overflow_d = 1'b0;

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase

    rd_done_d = rd_hit;
    dout_d    = (rd_hit && (bus.i_p_addr == STAT_ADDR)) ? status : 8'h00;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      fifo_q     <= '{default: 8'h00};
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      rd_done_q  <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_done_q  <= rd_done_d;
      dout_q     <= dout_d;
    end
  end

  assign o_tx            = tx_q;
  assign o_busy          = (count_q != 3'd0) || (state_q != S_IDLE);
  assign bus.o_p_rd_done = rd_done_q;
  assign bus.o_p_dout    = dout_q;

endmodule

// File: tb/tb_p_uart_tx.sv
// Directed bench for p_uart_tx at 4 clocks per bit and base address 8'h10.
module tb_p_uart_tx;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  p_uart_tx_if bus();

  p_uart_tx #(.P_BASE_ADDR(8'h10), .P_CLKS_PER_BIT(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus),
    .o_tx    (tx),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr, input logic [7:0] din);
    bus.i_p_wr_strobe = wr;
    bus.i_p_rd_strobe = rd;
    bus.i_p_addr      = addr;
    bus.i_p_din       = din;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Read completes one cycle after the strobe and lasts exactly one cycle.
  task automatic do_read(input string tag, input logic [7:0] addr, input logic exp_done, input logic [7:0] exp_dout);
    applyStimulus(1'b0, 1'b1, addr, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput({tag, "_done"}, {7'b0, bus.o_p_rd_done}, {7'b0, exp_done});
    checkOutput({tag, "_dout"}, bus.o_p_dout, exp_dout);
    tick();
    checkOutput({tag, "_done_end"}, {7'b0, bus.o_p_rd_done}, 8'h00);
    checkOutput({tag, "_dout_end"}, bus.o_p_dout, 8'h00);
  endtask

  // Called just after the edge that starts the frame; returns 40 cycles later.
  task automatic check_frame(input string tag, input logic [7:0] data);
    logic exp;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       exp = 1'b0;
      else if (i < 36) exp = data[(i - 4) / 4];
      else             exp = 1'b1;
      checkOutput($sformatf("%s_c%0d", tag, i), {7'b0, tx}, {7'b0, exp});
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] burst [6];
    burst = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'hFF, 8'h77};

    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    do_reset();
    checkOutput("rst_tx",      {7'b0, tx}, 8'h01);
    checkOutput("rst_busy",    {7'b0, busy}, 8'h00);
    checkOutput("rst_rd_done", {7'b0, bus.o_p_rd_done}, 8'h00);
    checkOutput("rst_dout",    bus.o_p_dout, 8'h00);

    // Register map basics while idle and empty
    do_read("rd_status_idle", 8'h11, 1'b1, 8'h02);
    do_read("rd_txdata", 8'h10, 1'b1, 8'h00);
    do_read("rd_nomatch", 8'h12, 1'b0, 8'h00);
    do_write(8'h12, 8'h55);
    tick();
    checkOutput("wr_nomatch_busy", {7'b0, busy}, 8'h00);
    checkOutput("wr_nomatch_tx",   {7'b0, tx}, 8'h01);

    // Single frame 8'hA5
    do_reset();
    do_write(8'h10, 8'hA5);
    tick();
    check_frame("a5", 8'hA5);
    checkOutput("a5_busy_after", {7'b0, busy}, 8'h00);
    checkOutput("a5_tx_after",   {7'b0, tx}, 8'h01);

    // Five back-to-back writes, five contiguous frames
    do_reset();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          applyStimulus(1'b1, 1'b0, 8'h10, burst[i]);
          tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      end
      begin
        tick();
        tick();
        for (int i = 0; i < 5; i++) check_frame($sformatf("burst%0d", i), burst[i]);
      end
    join
    checkOutput("burst_busy_after", {7'b0, busy}, 8'h00);
    do_read("burst_status", 8'h11, 1'b1, 8'h02);

    // Six writes: sixth dropped, sticky overflow, clear with simultaneous read
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h10, burst[i]);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    do_read("ovf_status", 8'h11, 1'b1, 8'h0D);
    applyStimulus(1'b1, 1'b1, 8'h11, 8'h08);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("rdwr_done", {7'b0, bus.o_p_rd_done}, 8'h01);
    checkOutput("rdwr_prewrite", bus.o_p_dout, 8'h0D);
    tick();
    do_read("ovf_cleared", 8'h11, 1'b1, 8'h05);

    // Reset during DATA bit 3 with two bytes queued; strobe during reset ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h10, 8'hF7);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (15) tick();
    checkOutput("mid_bit3_tx", {7'b0, tx}, 8'h00);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h10, 8'hFF);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("abort_tx",   {7'b0, tx}, 8'h01);
    checkOutput("abort_busy", {7'b0, busy}, 8'h00);
    tick();
    checkOutput("abort_busy2", {7'b0, busy}, 8'h00);
    do_read("abort_status", 8'h11, 1'b1, 8'h02);

    // Write into a full FIFO on the last STOP cycle is accepted
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h10, burst[i]);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (36) tick();
    checkOutput("last_stop_tx", {7'b0, tx}, 8'h01);
    do_write(8'h10, 8'h3C);
    checkOutput("next_start_tx", {7'b0, tx}, 8'h00);
    do_read("stop_push_status", 8'h11, 1'b1, 8'h05);
    do_write(8'h10, 8'hEE);
    do_read("full_drop_status", 8'h11, 1'b1, 8'h0D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p_uart_tx.md
P_UART_TX -- requirements
Module: p_uart_tx

Interface
REQ-001 Parameter P_BASE_ADDR, default 8'h10, is the peripheral-bus base address of the block's two registers.
REQ-002 Parameter P_CLKS_PER_BIT, default 868, is the number of i_clk cycles per UART bit; legal range is 2..65535.
REQ-003 One clock, i_clk; reset i_reset is synchronous and active-high.
REQ-004 i_clk  in  1  system clock; all logic is rising-edge.
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 i_p_wr_strobe  in  1  one-cycle peripheral write strobe from the CPU.
REQ-007 i_p_rd_strobe  in  1  one-cycle peripheral read strobe from the CPU.
REQ-008 i_p_addr  in  8  peripheral address.
REQ-009 i_p_din  in  8  write data from the CPU.
REQ-010 o_p_dout  out  8  read data to the CPU; 0 whenever o_p_rd_done is 0.
REQ-011 o_p_rd_done  out  1  one-cycle read-complete pulse.
REQ-012 o_tx  out  1  UART serial line, idle high.
REQ-013 o_busy  out  1  is 1 when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-014 Register map:
- BASE+0 TXDATA: a write pushes i_p_din into the TX FIFO; a read returns 8'h00.
- BASE+1 STATUS: a read returns {4'b0, overflow, tx_active, fifo_empty, fifo_full}; a write with i_p_din[3]=1 clears overflow, and all other bits are ignored.
REQ-015 The TX FIFO is 4 entries x 8 bits, first-in first-out, with a 3-bit occupancy count of 0..4.
REQ-016 A TXDATA write accepted while the FIFO is full after the same-cycle pop SHALL be dropped and SHALL set the sticky overflow bit; FIFO contents are unchanged.
REQ-017 A TXDATA write when count=4 and a pop in the same cycle SHALL be accepted, leaving count=4.
REQ-018 A read strobe with i_p_addr equal to BASE+0 or BASE+1 SHALL produce o_p_rd_done=1 and valid o_p_dout on the next cycle, for exactly one cycle; the data is sampled at the strobe cycle.
REQ-019 Non-matching addresses SHALL be ignored: no write effect, o_p_rd_done stays 0, and o_p_dout stays 0.
REQ-020 Simultaneous read and write strobes SHALL both be processed; read data reflects pre-write state.
REQ-021 The FSM has four states: IDLE, START, DATA, STOP.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the shift register and enter START on the next cycle.
REQ-023 In START, o_tx=0 for P_CLKS_PER_BIT cycles, then the FSM enters DATA.
REQ-024 In DATA, 8 bits are sent LSB first, each held P_CLKS_PER_BIT cycles; a 3-bit bit index wraps 7->0, then the FSM enters STOP.
REQ-025 In STOP, o_tx=1 for P_CLKS_PER_BIT cycles.
REQ-026 On the last STOP cycle, if the FIFO is non-empty, the FSM SHALL pop and go directly to START (no idle gap); otherwise it goes to IDLE.
REQ-027 The baud counter SHALL be 16 bits, count 0..P_CLKS_PER_BIT-1, and reload to 0 on every state change.
REQ-028 tx_active SHALL be 1 in START, DATA and STOP.
REQ-029 o_tx SHALL be registered (glitch-free) and 1 in IDLE.
REQ-030 A frame is 10 bit periods; the first START cycle occurs one cycle after the pop.

Reset
REQ-031 On i_reset=1 at a clock edge: o_tx=1, o_busy=0, o_p_rd_done=0, o_p_dout=0, FIFO count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0.
REQ-032 Reset mid-frame SHALL abort the frame; o_tx returns to 1 on the cycle after the reset edge, and queued bytes are discarded.
REQ-033 Strobes asserted during reset SHALL be ignored.

Verification (P_CLKS_PER_BIT=4, P_BASE_ADDR=8'h10)
REQ-034 Write 8'hA5 to 8'h10 -> o_tx is low for 4 cycles starting 2 cycles after the strobe, then 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles; o_busy=0 afterwards.
REQ-035 Write 5 bytes back-to-back while the FSM is idle -> the first pops immediately and all 5 frames transmit contiguously with no gap; overflow stays 0.
REQ-036 Write 6 bytes in 6 consecutive cycles while idle -> the 6th is dropped; reading 8'h11 returns bit3=1; writing 8'h08 to 8'h11 then reading 8'h11 returns bit3=0.
REQ-037 Read 8'h11 while idle and empty -> o_p_rd_done=1 one cycle later with o_p_dout=8'h02; read 8'h12 -> o_p_rd_done stays 0.
REQ-038 Assert i_reset during DATA bit 3 with 2 bytes queued -> the next cycle has o_tx=1, o_busy=0, and status reads 8'h02.
REQ-039 Write to a full FIFO on the last STOP cycle -> the byte is accepted, overflow=0, and count stays 4.
